beat_pattern_gen: RTL and testbench

BEAT_PATTERN_GEN -- requirements
Module: beat_pattern_gen

---
 rtl/beat_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_beat_pattern_gen.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_pattern_gen.sv
// Programmable note-sequence generator: steps a note value through up-wrap,
// down-wrap, ping-pong or hold patterns, one beat per divider period, with valid/ready output.
module beat_pattern_gen #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] start_val,
  input  logic [DATA_W-1:0] end_val,
  input  logic [DATA_W-1:0] step_val,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic              enable,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [7:0]        seq_cnt
);

  typedef enum logic [1:0] {IDLE, COUNT, PRESENT} state_t;

  state_t             state;
  logic [DATA_W-1:0]  cfg_start;
  logic [DATA_W-1:0]  cfg_end;
  logic [DATA_W-1:0]  cfg_step;
  logic [1:0]         cfg_mode;
  logic [DIV_W-1:0]   cfg_div;
  logic [DIV_W-1:0]   count;
  logic [DATA_W-1:0]  cur;
  logic               dir_down;

  logic [DATA_W-1:0]  nxt;
  logic               nxt_last;
  logic               nxt_down;
  logic [DATA_W:0]    cur_x;
  logic [DATA_W:0]    start_x;
  logic [DATA_W:0]    end_x;
  logic [DATA_W:0]    step_x;
  logic [DATA_W:0]    sum;
  logic [DATA_W:0]    diff;
  logic [DATA_W:0]    end_plus;
  logic [DATA_W:0]    start_plus;

  // One extra bit keeps cur+step and end+step from wrapping; diff is only used when cur >= step.
  always_comb begin
    cur_x      = {1'b0, cur};
    start_x    = {1'b0, cfg_start};
    end_x      = {1'b0, cfg_end};
    step_x     = {1'b0, cfg_step};
    sum        = cur_x + step_x;
    diff       = cur_x - step_x;
    end_plus   = end_x + step_x;
    start_plus = start_x + step_x;
    nxt        = cur;
    nxt_last   = 1'b0;
    nxt_down   = dir_down;
    if (cfg_mode != 2'b11 && cfg_step != '0) begin
      case (cfg_mode)
        2'b00: begin
          if (sum > end_x) begin
            nxt_last = 1'b1;
            nxt      = cfg_start;
          end else begin
            nxt = sum[DATA_W-1:0];
          end
        end
        2'b01: begin
          if (cur_x < end_plus) begin
            nxt_last = 1'b1;
            nxt      = cfg_start;
          end else begin
            nxt = diff[DATA_W-1:0];
          end
        end
        2'b10: begin
          if (!dir_down) begin
            if (sum > end_x) begin
              nxt_down = 1'b1;
              nxt      = (cur_x < start_plus) ? cfg_start : diff[DATA_W-1:0];
            end else begin
              nxt = sum[DATA_W-1:0];
            end
          end else begin
            if (cur_x < start_plus) begin
              nxt_last = 1'b1;
              nxt_down = 1'b0;
              nxt      = (sum > end_x) ? cfg_start : sum[DATA_W-1:0];
            end else begin
              nxt = diff[DATA_W-1:0];
            end
          end
        end
        default: nxt = cur;
      endcase
    end
  end

  // cfg_load takes priority over a same-cycle handshake, so a pending beat is simply dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cfg_start <= '0;
      cfg_end   <= '0;
      cfg_step  <= '0;
      cfg_mode  <= '0;
      cfg_div   <= '0;
      count     <= '0;
      cur       <= '0;
      dir_down  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      seq_cnt   <= '0;
    end else if (cfg_load) begin
      cfg_start <= start_val;
      cfg_end   <= end_val;
      cfg_step  <= step_val;
      cfg_mode  <= mode;
      cfg_div   <= div;
      cur       <= start_val;
      count     <= '0;
      dir_down  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      state     <= COUNT;
    end else begin
      case (state)
        IDLE: out_valid <= 1'b0;
        COUNT: begin
          if (enable) begin
            if (count == cfg_div) begin
              count     <= '0;
              out_valid <= 1'b1;
              out_data  <= cur;
              out_last  <= nxt_last;
              state     <= PRESENT;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            cur       <= nxt;
            dir_down  <= nxt_down;
            out_valid <= 1'b0;
            if (out_last) seq_cnt <= seq_cnt + 8'd1;
            state     <= COUNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beat_pattern_gen.sv
// Scoreboard bench for beat_pattern_gen: stimulus queues expected beats,
// a negedge monitor compares every presented beat and handshake against them.
module tb_beat_pattern_gen;
  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  logic              clk;
  logic              resetn;
  logic              cfg_load;
  logic [DATA_W-1:0] start_val;
  logic [DATA_W-1:0] end_val;
  logic [DATA_W-1:0] step_val;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
  logic              enable;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic [7:0]        seq_cnt;

  typedef struct {int data; bit last;} beat_t;
  beat_t exp_q[$];
  int checks = 0;
  int fails = 0;
  int exp_seq = 0;
  int cyc = 0;

  beat_pattern_gen #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .resetn(resetn), .cfg_load(cfg_load),
    .start_val(start_val), .end_val(end_val), .step_val(step_val),
    .mode(mode), .div(div), .enable(enable), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .seq_cnt(seq_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_beat(input int d, input bit l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  // Values of 1000 and above mark the last beat of a pass (data = value - 1000).
  task automatic push_list(input int v[$]);
    foreach (v[i]) push_beat(v[i] >= 1000 ? v[i] - 1000 : v[i], v[i] >= 1000);
  endtask

  // Reference sequence straight from the pattern rules, using plain integers.
  task automatic model_push(input int s, input int e, input int st, input int m, input int n);
    int c;
    bit down;
    c = s;
    down = 0;
    for (int i = 0; i < n; i++) begin
      if (m == 3 || st == 0) begin
        push_beat(c, 0);
      end else if (m == 0) begin
        if (c + st > e) begin push_beat(c, 1); c = s; end
        else begin push_beat(c, 0); c = c + st; end
      end else if (m == 1) begin
        if (c < e + st) begin push_beat(c, 1); c = s; end
        else begin push_beat(c, 0); c = c - st; end
      end else if (!down) begin
        push_beat(c, 0);
        if (c + st > e) begin
          down = 1;
          c = (c - st < s) ? s : c - st;
        end else c = c + st;
      end else begin
        if (c - st < s) begin
          push_beat(c, 1);
          down = 0;
          c = (c + st > e) ? s : c + st;
        end else begin
          push_beat(c, 0);
          c = c - st;
        end
      end
    end
  endtask

  // Monitor: compare any presented beat against the queue head; pop on handshake.
  always @(negedge clk) begin
    if (resetn && !cfg_load && out_valid) begin
      if (exp_q.size() == 0) begin
        if (out_ready) check_output("unexpected_beat", 1, 0);
      end else begin
        check_output("beat_data", int'(out_data), exp_q[0].data);
        check_output("beat_last", int'(out_last), int'(exp_q[0].last));
        if (out_ready) begin
          check_output("seq_cnt", int'(seq_cnt), exp_seq);
          if (exp_q[0].last) exp_seq = (exp_seq + 1) % 256;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic apply_stimulus(input int s, input int e, input int st, input int m,
                                input int d, input bit use_model);
    exp_q.delete();
    start_val = 8'(s);
    end_val   = 8'(e);
    step_val  = 8'(st);
    mode      = 2'(m);
    div       = 16'(d);
    cfg_load  = 1'b1;
    if (use_model) model_push(s, e, st, m, 64);
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    start_val = 8'($urandom);
    end_val   = 8'($urandom);
    step_val  = 8'($urandom);
    mode      = 2'($urandom);
    div       = 16'($urandom_range(0, 50));
  endtask

  task automatic wait_handshake(output int c);
    bit got;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (resetn && !cfg_load && out_valid && out_ready) got = 1;
    end
    @(posedge clk); #1;
    c = cyc;
    check_output("handshake_seen", int'(got), 1);
  endtask

  task automatic run_beats(input int n, input int period);
    int c0, c1;
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_handshake(c0);
    for (int i = 1; i < n; i++) begin
      wait_handshake(c1);
      if (period > 0) check_output("beat_period", c1 - c0, period);
      c0 = c1;
    end
    out_ready = 1'b0;
  endtask

  task automatic wait_valid();
    bit got;
    got = 0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(posedge clk); #1;
      if (out_valid) got = 1;
    end
    check_output("valid_seen", int'(got), 1);
  endtask

  initial begin
    int q[$];
    int c0, c1, c2;
    resetn = 1'b0; cfg_load = 1'b0; start_val = '0; end_val = '0; step_val = '0;
    mode = '0; div = '0; enable = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_valid", int'(out_valid), 0);
    check_output("reset_data", int'(out_data), 0);
    check_output("reset_last", int'(out_last), 0);
    check_output("reset_seq", int'(seq_cnt), 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Up-wrap, down-wrap, ping-pong and top-of-range directed sequences.
    apply_stimulus(60, 76, 4, 0, 0, 0);
    q = '{60, 64, 68, 72, 1076, 60, 64};
    push_list(q);
    run_beats(7, 2);

    apply_stimulus(76, 60, 4, 1, 0, 0);
    q = '{76, 72, 68, 64, 1060, 76};
    push_list(q);
    run_beats(6, 2);

    apply_stimulus(250, 0, 10, 1, 0, 0);
    for (int v = 250; v >= 0; v -= 10) push_beat(v, v == 0);
    push_beat(250, 0);
    run_beats(27, 2);

    apply_stimulus(60, 68, 4, 2, 0, 0);
    q = '{60, 64, 68, 64, 1060, 64, 68};
    push_list(q);
    run_beats(7, 2);

    apply_stimulus(248, 255, 4, 0, 0, 0);
    q = '{248, 1252, 248, 1252};
    push_list(q);
    run_beats(4, 2);

    // Degenerate bounds must keep producing start with last set.
    apply_stimulus(100, 50, 3, 0, 0, 0);
    q = '{1100, 1100, 1100};
    push_list(q);
    run_beats(3, 2);
    apply_stimulus(10, 90, 5, 1, 1, 0);
    q = '{1010, 1010, 1010};
    push_list(q);
    run_beats(3, 3);

    // Backpressure: beat held for 5 cycles, monitor re-checks it every cycle.
    apply_stimulus(10, 30, 5, 0, 1, 0);
    q = '{10, 15, 20};
    push_list(q);
    out_ready = 1'b0;
    enable    = 1'b1;
    wait_valid();
    repeat (5) @(posedge clk);
    #1;
    run_beats(3, 3);

    // Pause: div=3 with enable low for 2 cycles stretches the period to 7.
    apply_stimulus(1, 100, 1, 0, 3, 0);
    q = '{1, 2, 3};
    push_list(q);
    out_ready = 1'b1;
    enable    = 1'b1;
    wait_handshake(c0);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    wait_handshake(c1);
    check_output("paused_period", c1 - c0, 7);
    wait_handshake(c2);
    check_output("plain_period", c2 - c1, 5);
    out_ready = 1'b0;

    // Reload while a beat is stalled: it is dropped and the new start comes first.
    apply_stimulus(20, 40, 2, 0, 0, 0);
    push_beat(20, 0);
    out_ready = 1'b0;
    wait_valid();
    apply_stimulus(33, 90, 7, 0, 0, 0);
    check_output("reload_valid", int'(out_valid), 0);
    q = '{33, 40, 47};
    push_list(q);
    run_beats(3, 2);

    // Reset pulse mid-run clears everything and parks in IDLE.
    apply_stimulus(5, 200, 3, 2, 1, 1);
    out_ready = 1'b1;
    enable    = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_output("midreset_valid", int'(out_valid), 0);
    check_output("midreset_data", int'(out_data), 0);
    check_output("midreset_last", int'(out_last), 0);
    check_output("midreset_seq", int'(seq_cnt), 0);
    exp_q.delete();
    exp_seq = 0;
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_output("idle_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;

    // Random configurations with random ready/enable and churning config inputs.
    for (int t = 0; t < 30; t++) begin
      int s, e, st, m, d;
      s  = $urandom_range(0, 255);
      e  = $urandom_range(0, 255);
      st = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
      m  = $urandom_range(0, 3);
      d  = $urandom_range(0, 3);
      apply_stimulus(s, e, st, m, d, 1);
      repeat ($urandom_range(20, 80)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        enable    = ($urandom_range(0, 3) != 0);
        start_val = 8'($urandom);
        step_val  = 8'($urandom);
        @(posedge clk); #1;
      end
    end

    out_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_output("final_seq_cnt", int'(seq_cnt), exp_seq);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
